// File: rtl/dm_resp_pkg.sv
// Shared types for the data-memory responder: FSM state, latched op and wait-counter width.
package dm_resp_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // A simultaneous read+write request is served as a write.
    function automatic op_t op_from_req(input logic rd, input logic wr);
        return (wr || !rd) ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/dm_wait_counter.sv
// Wait-state countdown for the responder: loaded on request accept, decremented while waiting.
module dm_wait_counter
    import dm_resp_pkg::*;
#(
    parameter logic [WAIT_W-1:0] LOAD_VAL = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    output logic [WAIT_W-1:0] count,
    output logic              last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WAIT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the datapath load/store port: one transaction at a time with programmable wait states.
// Optional build macro DM_RESP_RANGE_CHECK_EN flags addresses beyond DEPTH with dm_err instead of wrapping.
module data_mem_responder
    import dm_resp_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data_rd,
    output logic              dm_ready,
    output logic              dm_err
);

    // Handshake: the requester holds dm_rd/dm_wr (with addr/wdata) until dm_ready pulses for one
    // cycle; a request still high when the FSM is back in IDLE starts a new transaction.
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t              state;
    state_t              state_nxt;
    op_t                 op_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                oor_q;
    logic                addr_oor;
    logic                req;
    logic                accept;
    logic                wait_load;
    logic                wait_dec;
    logic [WAIT_W-1:0]   wait_count;
    logic                wait_last;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DM_RESP_RANGE_CHECK_EN
    assign addr_oor = (addr >> ADDR_W) != 32'd0;
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[31:ADDR_W];
    assign addr_oor       = 1'b0;
`endif

    assign req    = dm_rd | dm_wr;
    assign accept = (state == ST_IDLE) && req;

    dm_wait_counter #(
        .LOAD_VAL(WAIT_CYCLES[WAIT_W-1:0])
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (wait_load),
        .dec  (wait_dec),
        .count(wait_count),
        .last (wait_last)
    );

    always_comb begin
        state_nxt = state;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    wait_load = 1'b1;
                    state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_dec = 1'b1;
                // A zero count can only appear if the load value wrapped; never stall on it.
                if (wait_last || wait_count == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            data_rd  <= '0;
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;
            op_q     <= OP_RD;
            idx_q    <= '0;
            wdata_q  <= '0;
            oor_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            dm_ready <= (state == ST_RESP);
            dm_err   <= (state == ST_RESP) && oor_q;
            if (accept) begin
                op_q    <= op_from_req(dm_rd, dm_wr);
                idx_q   <= addr[ADDR_W-1:0];
                wdata_q <= wdata;
                oor_q   <= addr_oor;
            end
            if (state == ST_RESP && op_q == OP_RD) begin
                data_rd <= oor_q ? '0 : mem[idx_q];
            end
        end
    end

    // RAM has no reset so its contents survive rst; state is IDLE while rst is high.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && op_q == OP_WR && !oor_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3), directed cases then random traffic.
// Honours DM_RESP_RANGE_CHECK_EN the same way the design does.
module tb_data_mem_responder;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        dm_rd    [3];
    logic        dm_wr    [3];
    logic [31:0] addr     [3];
    logic [31:0] wdata    [3];
    logic [31:0] data_rd  [3];
    logic        dm_ready [3];
    logic        dm_err   [3];

    int          wc_tab [3] = '{1, 0, 3};
    logic [31:0] model_mem [3][32];
    logic [31:0] model_rd  [3];
    exp_t        exp_q[$];
    int          cyc;
    int          n_checks;
    int          n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        data_mem_responder #(
            .DATA_W(32),
            .ADDR_W(5),
            .WAIT_CYCLES(WC)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .dm_rd   (dm_rd[g]),
            .dm_wr   (dm_wr[g]),
            .addr    (addr[g]),
            .wdata   (wdata[g]),
            .data_rd (data_rd[g]),
            .dm_ready(dm_ready[g]),
            .dm_err  (dm_err[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef DM_RESP_RANGE_CHECK_EN
        return a >= 32'd32;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (dm_ready[g]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 32'(g), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ready_inst", 32'(g), 32'(e.inst));
                        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                        chk("data_rd", data_rd[g], e.data);
                        chk("dm_err", {31'd0, dm_err[g]}, {31'd0, e.err});
                    end
                end else begin
                    if (dm_err[g]) chk("err_without_ready", 32'd1, 32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a negedge; returns at the negedge where dm_ready is seen, request still held.
    task automatic issue(input int inst, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        logic oor;
        logic got;
        dm_rd[inst] = rd;
        dm_wr[inst] = wr;
        addr[inst]  = a;
        wdata[inst] = wd;
        oor = out_of_range(a);
        if (wr) begin
            if (!oor) model_mem[inst][a[4:0]] = wd;
        end else begin
            model_rd[inst] = oor ? 32'd0 : model_mem[inst][a[4:0]];
        end
        e.inst = inst;
        e.data = model_rd[inst];
        e.err  = oor;
        e.cyc  = cyc + 2 + wc_tab[inst];
        exp_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = dm_ready[inst];
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int inst, input int n);
        dm_rd[inst] = 1'b0;
        dm_wr[inst] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drop_all();
        for (int g = 0; g < 3; g++) begin
            dm_rd[g] = 1'b0;
            dm_wr[g] = 1'b0;
        end
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear, releases before the next posedge.
    task automatic async_reset_check(input int inst, input string tag);
        #2;
        rst = 1'b1;
        drop_all();
        #1;
        chk({tag, "_data_rd"}, data_rd[inst], 32'd0);
        chk({tag, "_dm_ready"}, {31'd0, dm_ready[inst]}, 32'd0);
        chk({tag, "_dm_err"}, {31'd0, dm_err[inst]}, 32'd0);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) model_rd[g] = 32'd0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        int          op;
        n_checks = 0;
        n_fail   = 0;
        for (int g = 0; g < 3; g++) begin
            model_rd[g] = 32'd0;
            for (int i = 0; i < 32; i++) model_mem[g][i] = 32'd0;
        end
        drop_all();
        for (int g = 0; g < 3; g++) begin
            addr[g]  = 32'd0;
            wdata[g] = 32'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("reset_data_rd", data_rd[g], 32'd0);
            chk("reset_dm_ready", {31'd0, dm_ready[g]}, 32'd0);
            chk("reset_dm_err", {31'd0, dm_err[g]}, 32'd0);
        end
        @(negedge clk);

        // WAIT_CYCLES=1: write then read back addr 3
        issue(0, 1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF);
        idle(0, 2);
        issue(0, 1'b1, 1'b0, 32'd3, 32'h0);
        idle(0, 2);

        // WAIT_CYCLES=0: back-to-back, ready every second cycle
        issue(1, 1'b0, 1'b1, 32'd0, 32'h0000_0001);
        issue(1, 1'b0, 1'b1, 32'd31, 32'hFFFF_FFFF);
        issue(1, 1'b1, 1'b0, 32'd0, 32'h0);
        issue(1, 1'b1, 1'b0, 32'd31, 32'h0);
        idle(1, 2);

        // rd and wr together behave as a write; data_rd keeps DEADBEEF
        issue(0, 1'b1, 1'b1, 32'd5, 32'h55);
        idle(0, 1);
        issue(0, 1'b1, 1'b0, 32'd5, 32'h0);
        idle(0, 1);

        // Address above DEPTH: wraps to 0, or flagged when range checking is built in
        issue(0, 1'b0, 1'b1, 32'h20, 32'h77);
        idle(0, 1);
        issue(0, 1'b1, 1'b0, 32'd0, 32'h0);
        idle(0, 1);
        issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
        idle(0, 1);

        // Async reset while dm_ready and a nonzero data_rd are showing
        issue(2, 1'b1, 1'b0, 32'd9, 32'h0);
        idle(2, 1);
        issue(2, 1'b0, 1'b1, 32'd9, 32'hA5A5_5A5A);
        issue(2, 1'b1, 1'b0, 32'd9, 32'h0);
        async_reset_check(2, "rst_at_ready");

        // Reset during WAIT of a write to addr 7: aborted, no ready, memory untouched
        dm_rd[2] = 1'b0;
        dm_wr[2] = 1'b1;
        addr[2]  = 32'd7;
        wdata[2] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        async_reset_check(2, "rst_in_wait");
        repeat (8) @(negedge clk);
        issue(2, 1'b1, 1'b0, 32'd7, 32'h0);
        idle(2, 1);

        // Random traffic on every instance
        for (int g = 0; g < 3; g++) begin
            for (int t = 0; t < 25; t++) begin
                op = $urandom_range(0, 3);
                ra = ($urandom_range(0, 4) == 0) ? (32'($urandom_range(1, 255)) << 5) : 32'd0;
                ra = ra | 32'($urandom_range(0, 31));
                issue(g, (op != 2), (op >= 2), ra, $urandom());
                if ($urandom_range(0, 1) == 1) idle(g, $urandom_range(1, 3));
            end
            idle(g, 2);
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
